// File: rtl/sync_debounce_pkg.sv
// Shared types and default constants for the sync_debounce block.
package sync_debounce_pkg;

    // Debounce FSM: stable low/high plus one checking state per direction.
    typedef enum logic [1:0] {
        ST_LO  = 2'd0,
        CHK_HI = 2'd1,
        ST_HI  = 2'd2,
        CHK_LO = 2'd3
    } state_e;

    localparam int unsigned DEF_SYNC_STAGES     = 2;
    localparam int unsigned DEF_DEBOUNCE_CYCLES = 4;
    localparam int unsigned DEF_CNT_W           = 8;

    // Debounced level implied by a state.
    function automatic logic state_is_high(input state_e s);
        return (s == ST_HI) || (s == CHK_LO);
    endfunction

endpackage

// File: rtl/sync_chain.sv
// Multi-flop synchronizer for a single asynchronous level input.
module sync_chain
    import sync_debounce_pkg::*;
#(
    parameter int unsigned STAGES = DEF_SYNC_STAGES
) (
    input  logic clk,
    input  logic rst,
    input  logic d,
    output logic q
);

    logic [STAGES-1:0] chain;

    // Shift d through the chain; reset clears every stage.
    always_ff @(posedge clk) begin
        if (rst) begin
            chain <= '0;
        end else begin
            chain <= {chain[STAGES-2:0], d};
        end
    end

    assign q = chain[STAGES-1];

endmodule

// File: rtl/sync_debounce.sv
// Synchronizer + debouncer with registered level, edge pulses and an optional
// rise counter. Define SYNC_DEBOUNCE_RISE_CNT_EN to build rise_cnt and clr;
// otherwise rise_cnt is tied to zero and clr is ignored.
module sync_debounce
    import sync_debounce_pkg::*;
#(
    parameter int unsigned SYNC_STAGES     = DEF_SYNC_STAGES,
    parameter int unsigned DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES,
    parameter int unsigned CNT_W           = DEF_CNT_W
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             d,
    input  logic             clr,
    output logic             q,
    output logic             rise,
    output logic             fall,
    output logic [CNT_W-1:0] rise_cnt
);

    localparam int unsigned SCNT_W = $clog2(DEBOUNCE_CYCLES + 1);
    // Count value at which the next matching sample completes the debounce.
    localparam logic [SCNT_W-1:0] SCNT_LAST = SCNT_W'(DEBOUNCE_CYCLES - 1);

    logic              d_sync;
    state_e            state;
    state_e            state_nxt;
    logic [SCNT_W-1:0] scnt;
    logic [SCNT_W-1:0] scnt_nxt;
    logic              q_nxt;

    sync_chain #(
        .STAGES (SYNC_STAGES)
    ) u_sync_chain (
        .clk (clk),
        .rst (rst),
        .d   (d),
        .q   (d_sync)
    );

    // Next-state logic: count consecutive opposite-level samples before flipping.
    always_comb begin
        state_nxt = state;
        scnt_nxt  = scnt;
        unique case (state)
            ST_LO: begin
                if (d_sync) begin
                    if (DEBOUNCE_CYCLES == 1) begin
                        state_nxt = ST_HI;
                        scnt_nxt  = '0;
                    end else begin
                        state_nxt = CHK_HI;
                        scnt_nxt  = SCNT_W'(1);
                    end
                end
            end
            CHK_HI: begin
                if (!d_sync) begin
                    state_nxt = ST_LO;
                    scnt_nxt  = '0;
                end else if (scnt == SCNT_LAST) begin
                    state_nxt = ST_HI;
                    scnt_nxt  = '0;
                end else begin
                    scnt_nxt = scnt + 1'b1;
                end
            end
            ST_HI: begin
                if (!d_sync) begin
                    if (DEBOUNCE_CYCLES == 1) begin
                        state_nxt = ST_LO;
                        scnt_nxt  = '0;
                    end else begin
                        state_nxt = CHK_LO;
                        scnt_nxt  = SCNT_W'(1);
                    end
                end
            end
            CHK_LO: begin
                if (d_sync) begin
                    state_nxt = ST_HI;
                    scnt_nxt  = '0;
                end else if (scnt == SCNT_LAST) begin
                    state_nxt = ST_LO;
                    scnt_nxt  = '0;
                end else begin
                    scnt_nxt = scnt + 1'b1;
                end
            end
        endcase
        q_nxt = state_is_high(state_nxt);
    end

    // State, debounced level and edge pulses all update on the same edge.
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= ST_LO;
            scnt  <= '0;
            q     <= 1'b0;
            rise  <= 1'b0;
            fall  <= 1'b0;
        end else begin
            state <= state_nxt;
            scnt  <= scnt_nxt;
            q     <= q_nxt;
            rise  <= q_nxt & ~q;
            fall  <= ~q_nxt & q;
        end
    end

`ifdef SYNC_DEBOUNCE_RISE_CNT_EN
    // Count rise pulses; clr wins over a same-cycle increment, wraps naturally.
    always_ff @(posedge clk) begin
        if (rst) begin
            rise_cnt <= '0;
        end else if (clr) begin
            rise_cnt <= '0;
        end else if (rise) begin
            rise_cnt <= rise_cnt + 1'b1;
        end
    end
`else
    logic unused_clr;
    assign unused_clr = clr;
    assign rise_cnt   = '0;
`endif

endmodule

// File: tb/tb_sync_debounce.sv
// Scoreboard bench for sync_debounce: a default instance (latency 6 from the
// drive point) and a DEBOUNCE_CYCLES=1 instance (latency 3). Expected pulses
// are queued by the stimulus and popped by per-instance monitors.
module tb_sync_debounce;

`ifdef SYNC_DEBOUNCE_RISE_CNT_EN
    localparam bit CNT_ON = 1'b1;
`else
    localparam bit CNT_ON = 1'b0;
`endif

    // Hand-computed: drive after edge n -> q changes at edge n + 2 + 4 (or n + 2 + 1).
    localparam int unsigned LAT_A = 6;
    localparam int unsigned LAT_B = 3;

    typedef struct {
        bit          is_rise;
        int unsigned cyc;
        int unsigned cnt;
    } ev_t;

    logic       clk = 1'b0;
    logic       rst, d, d2, clr;
    logic       q, rise, fall, q2, rise2, fall2;
    logic [7:0] rise_cnt, rise_cnt2;

    int unsigned cyc = 0;
    int unsigned n_pass = 0;
    int unsigned n_total = 0;
    int unsigned model_a = 0;
    int unsigned model_b = 0;
    ev_t         exp_a[$];
    ev_t         exp_b[$];

    sync_debounce #(
        .SYNC_STAGES     (2),
        .DEBOUNCE_CYCLES (4),
        .CNT_W           (8)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .d        (d),
        .clr      (clr),
        .q        (q),
        .rise     (rise),
        .fall     (fall),
        .rise_cnt (rise_cnt)
    );

    sync_debounce #(
        .SYNC_STAGES     (2),
        .DEBOUNCE_CYCLES (1),
        .CNT_W           (8)
    ) dut_fast (
        .clk      (clk),
        .rst      (rst),
        .d        (d2),
        .clr      (clr),
        .q        (q2),
        .rise     (rise2),
        .fall     (fall2),
        .rise_cnt (rise_cnt2)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_total++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, got, exp, cyc);
    endtask

    function automatic int unsigned cnt_view(input int unsigned m);
        return CNT_ON ? (m % 256) : 0;
    endfunction

    function automatic ev_t mk(input bit r, input int unsigned c, input int unsigned n);
        ev_t e;
        e.is_rise = r;
        e.cyc     = c;
        e.cnt     = n;
        return e;
    endfunction

    // Expected pulse for the default instance, due LAT_A edges from now.
    task automatic push_a(input bit r);
        exp_a.push_back(mk(r, cyc + LAT_A, cnt_view(model_a)));
        if (r) model_a++;
    endtask

    task automatic push_b(input bit r, input int unsigned lat);
        exp_b.push_back(mk(r, cyc + lat, cnt_view(model_b)));
        if (r) model_b++;
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // Monitor: every pulse on the default instance must match the queue head.
    always @(negedge clk) begin
        if (rise === 1'b1 || fall === 1'b1) begin
            if (exp_a.size() == 0) begin
                check("a_unexpected_pulse", {rise, fall}, 0);
            end else begin
                ev_t e;
                e = exp_a.pop_front();
                check("a_pulse_kind", rise, e.is_rise);
                check("a_pulse_excl", rise & fall, 0);
                check("a_pulse_cycle", cyc, e.cyc);
                check("a_pulse_q", q, e.is_rise);
                check("a_pulse_cnt", rise_cnt, e.cnt);
            end
        end
    end

    // Monitor for the single-sample debounce instance.
    always @(negedge clk) begin
        if (rise2 === 1'b1 || fall2 === 1'b1) begin
            if (exp_b.size() == 0) begin
                check("b_unexpected_pulse", {rise2, fall2}, 0);
            end else begin
                ev_t e;
                e = exp_b.pop_front();
                check("b_pulse_kind", rise2, e.is_rise);
                check("b_pulse_excl", rise2 & fall2, 0);
                check("b_pulse_cycle", cyc, e.cyc);
                check("b_pulse_q", q2, e.is_rise);
                check("b_pulse_cnt", rise_cnt2, e.cnt);
            end
        end
    end

    initial begin
        rst = 1'b1;
        d   = 1'b0;
        d2  = 1'b0;
        clr = 1'b0;
        tick(3);
        rst = 1'b0;

        // Idle low after reset.
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            check("idle_q", q, 0);
            check("idle_cnt", rise_cnt, 0);
            check("idle_q_fast", q2, 0);
        end
        tick(1);

        // Two-cycle glitch is filtered.
        d = 1'b1;
        tick(2);
        d = 1'b0;
        tick(10);
        check("glitch_q", q, 0);
        check("glitch_cnt", rise_cnt, 0);

        // Clean rise: q still low one edge before the deadline, high at it.
        push_a(1'b1);
        d = 1'b1;
        tick(5);
        check("rise_early_q", q, 0);
        tick(1);
        check("rise_q", q, 1);
        tick(4);
        check("rise_cnt_after", rise_cnt, cnt_view(model_a));

        // Low glitch while high is filtered, then a clean fall.
        d = 1'b0;
        tick(2);
        d = 1'b1;
        tick(10);
        check("low_glitch_q", q, 1);
        push_a(1'b0);
        d = 1'b0;
        tick(10);
        check("fall_q", q, 0);

        // Reset in CHK_HI abandons the transition; a held input then rises cleanly.
        d = 1'b1;
        tick(3);
        rst     = 1'b1;
        model_a = 0;
        model_b = 0;
        tick(1);
        check("rst_q", q, 0);
        check("rst_rise", rise, 0);
        check("rst_cnt", rise_cnt, 0);
        tick(1);
        rst = 1'b0;
        push_a(1'b1);
        tick(5);
        check("post_rst_early_q", q, 0);
        tick(1);
        check("post_rst_q", q, 1);
        tick(4);
        push_a(1'b0);
        d = 1'b0;
        tick(10);

        // Plain clear.
        clr = 1'b1;
        tick(1);
        clr     = 1'b0;
        model_a = 0;
        check("clr_cnt", rise_cnt, 0);

        // 256 rises: counter reaches 255 then wraps to 0.
        for (int i = 0; i < 256; i++) begin
            push_a(1'b1);
            d = 1'b1;
            tick(10);
            push_a(1'b0);
            d = 1'b0;
            tick(10);
            if (i == 254) check("cnt_255", rise_cnt, cnt_view(255));
        end
        check("cnt_wrap", rise_cnt, 0);

        // One more rise (count 1), then clr coinciding with a rise pulse.
        push_a(1'b1);
        d = 1'b1;
        tick(10);
        push_a(1'b0);
        d = 1'b0;
        tick(10);
        check("cnt_one", rise_cnt, cnt_view(1));
        push_a(1'b1);
        d = 1'b1;
        tick(6);
        check("clr_rise_pulse", rise, 1);
        clr = 1'b1;
        tick(1);
        clr     = 1'b0;
        model_a = 0;
        check("clr_vs_rise", rise_cnt, 0);
        tick(3);
        push_a(1'b0);
        d = 1'b0;
        tick(10);

        // Single-sample debounce: latency equals the sync depth plus one edge.
        push_b(1'b1, LAT_B);
        d2 = 1'b1;
        tick(2);
        check("fast_early_q", q2, 0);
        tick(1);
        check("fast_q", q2, 1);
        tick(5);
        push_b(1'b0, LAT_B);
        d2 = 1'b0;
        tick(5);
        check("fast_fall_q", q2, 0);

        // One-cycle input pulse passes through as back-to-back rise and fall.
        push_b(1'b1, LAT_B);
        exp_b.push_back(mk(1'b0, cyc + LAT_B + 1, cnt_view(model_b)));
        d2 = 1'b1;
        tick(1);
        d2 = 1'b0;
        tick(8);
        check("fast_glitch_q", q2, 0);

        tick(2);
        check("a_pending", exp_a.size(), 0);
        check("b_pending", exp_b.size(), 0);
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

// File: doc/sync_debounce.md
SYNC_DEBOUNCE -- requirements
Module: sync_debounce

Interface
REQ-001 SHALL have parameter SYNC_STAGES, default 2, number of synchronizer flops on d (legal >= 2).
REQ-002 SHALL have parameter DEBOUNCE_CYCLES, default 4, consecutive equal synchronized samples required to change q (legal >= 1).
REQ-003 SHALL have parameter CNT_W, default 8, width of rise_cnt.
REQ-004 SHALL have port clk  input  1  single clock, all state updates on rising edge.
REQ-005 SHALL have port rst  input  1  reset, synchronous, active-high.
REQ-006 SHALL have port d  input  1  raw asynchronous level input.
REQ-007 SHALL have port clr  input  1  synchronous clear of rise_cnt.
REQ-008 SHALL have port q  output  1  debounced, registered level.
REQ-009 SHALL have port rise  output  1  one-cycle pulse when q goes 0->1.
REQ-010 SHALL have port fall  output  1  one-cycle pulse when q goes 1->0.
REQ-011 SHALL have port rise_cnt  output  CNT_W  count of rise pulses.

Function
REQ-012 SHALL pass d through a SYNC_STAGES-deep flop chain; last stage is d_sync.
REQ-013 SHALL implement FSM states ST_LO, CHK_HI, ST_HI, CHK_LO; q = 1 in ST_HI and CHK_LO, else 0.
REQ-014 ST_LO: d_sync=1 -> CHK_HI with sample count 1; if DEBOUNCE_CYCLES=1, go directly to ST_HI instead.
REQ-015 CHK_HI: d_sync=1 -> increment count; on the DEBOUNCE_CYCLES-th consecutive sample -> ST_HI; d_sync=0 -> ST_LO, count cleared, no pulse.
REQ-016 ST_HI/CHK_LO SHALL mirror REQ-014/015 with levels inverted.
REQ-017 q, rise, fall SHALL be registered; rise/fall assert for exactly the cycle following the edge on which q changes.
REQ-018 Latency: d stable before edge k -> q changes at edge k+SYNC_STAGES+DEBOUNCE_CYCLES-1 (defaults: 5 edges).
REQ-019 Sample counter width SHALL be clog2(DEBOUNCE_CYCLES+1); it SHALL never exceed DEBOUNCE_CYCLES.
REQ-020 rise_cnt SHALL increment by 1 on each cycle rise=1, wrapping 2^CNT_W-1 -> 0.
REQ-021 clr SHALL have priority over an increment in the same cycle: rise_cnt -> 0.
REQ-022 rise and fall SHALL never be high in the same cycle.

Reset
REQ-023 rst on an edge SHALL force all sync flops to 0, state ST_LO, sample count 0, q=0, rise=0, fall=0, rise_cnt=0, regardless of d, clr, or current state.
REQ-024 Reset mid-CHK SHALL abandon the pending transition without emitting a pulse.
REQ-025 After rst deasserts with d held 1, q SHALL rise per REQ-018 counted from the first non-reset edge, with one rise pulse.

Configuration
REQ-026 Macro SYNC_DEBOUNCE_RISE_CNT_EN defined: rise_cnt counter and clr logic SHALL be built per REQ-020/021.
REQ-027 Macro undefined: rise_cnt SHALL be tied to 0, clr ignored, no counter flops; all other behaviour unchanged; port list identical.

Structure
REQ-028 Shared package sync_debounce_pkg SHALL hold the FSM state enum and the default parameter constants.
REQ-029 The synchronizer chain SHALL be a sub-module sync_chain (parameter STAGES; ports clk, rst, d, q).

Verification
REQ-030 Reset then d=0 for 10 cycles -> q=0, rise=fall=0, rise_cnt=0 throughout.
REQ-031 d 0->1 held (defaults) -> q=1 at 5th edge after first sampling, rise high exactly 1 cycle, rise_cnt=1.
REQ-032 d=1 pulse of 2 cycles then 0 (defaults) -> q stays 0, no pulses, rise_cnt unchanged.
REQ-033 Toggle d every 10 cycles 256 times with macro on (CNT_W=8) -> rise_cnt wraps 255->0; clr asserted with a rise -> rise_cnt=0.
REQ-034 rst asserted during CHK_HI -> next edge q=0, state ST_LO, no rise; macro off build -> rise_cnt constant 0.
REQ-035 DEBOUNCE_CYCLES=1 build: d 0->1 -> q=1 at edge SYNC_STAGES after sampling, single rise pulse.
